// File: rtl/shift_pkg.sv
// Shared widths, op encodings and FSM states for the multi-cycle shift sequencer.
package shift_pkg;

  localparam int XLEN = 64;
  localparam int NW   = $clog2(XLEN);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One bounded shift of up to MAX_STEP bits (SLL/SRL/SRA, reserved passes through).
// Latency: combinational.
// Backpressure: none, pure datapath.
module shift_step
  import shift_pkg::*;
#(
  parameter int MAX_STEP = 8,
  parameter int SW       = $clog2(MAX_STEP + 1)
) (
  input  logic [XLEN-1:0] acc,
  input  logic [SW-1:0]   step,
  input  logic [1:0]      op,
  output logic [XLEN-1:0] out
);

  always_comb begin
    out = acc;
    case (op)
      OP_SLL:  out = acc << step;
      OP_SRL:  out = acc >> step;
      OP_SRA:  out = $signed(acc) >>> step;
      default: out = acc;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequential 64-bit SLL/SRL/SRA: iterates MAX_STEP bits per cycle instead of a full barrel shifter.
// Latency: out_valid rises 1 + ceil(n/MAX_STEP) cycles after accept (1 for n==0 or reserved op).
// Backpressure: result held in DONE until out_ready; a new op may load on the consuming edge.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int MAX_STEP = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [NW-1:0]   n,
  input  logic [1:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SW = $clog2(MAX_STEP + 1);

  state_t          state, state_nxt;
  logic [XLEN-1:0] acc, acc_shf;
  logic [NW-1:0]   rem, rem_nxt;
  logic [1:0]      op_q;
  logic [SW-1:0]   step;
  logic            accept;
  logic            load_done;

  always_comb begin
    if (rem < NW'(MAX_STEP)) step = rem[SW-1:0];
    else                     step = SW'(MAX_STEP);
    rem_nxt = rem - NW'(step);
  end

  shift_step #(.MAX_STEP(MAX_STEP), .SW(SW)) u_step (
    .acc  (acc),
    .step (step),
    .op   (op_q),
    .out  (acc_shf)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = ~reset & ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
    accept    = in_valid & in_ready;
    load_done = (n == '0) | (op == OP_RSV);
    out_valid = (state == DONE);
    busy      = (state != IDLE);

    if (accept) begin
      state_nxt = load_done ? DONE : SHIFT;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        SHIFT:   if (rem_nxt == '0) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    // An abort wins over any handshake in the same cycle.
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      rem  <= '0;
      op_q <= OP_SLL;
    end else if (accept) begin
      acc  <= a;
      rem  <= n;
      op_q <= op;
    end else if ((state == SHIFT) && !flush) begin
      acc  <= acc_shf;
      rem  <= rem_nxt;
    end
  end

  assign result = acc;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboarded bench for shift_seq_ctrl: driver pushes model results, monitor pops on out_valid.
module tb_shift_seq_ctrl;
  import shift_pkg::*;

  localparam int MS = 8;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] a, result;
  logic [5:0]  n;
  logic [1:0]  op;

  shift_seq_ctrl #(.MAX_STEP(MS)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .n         (n),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          vcyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rdy_mode = 1;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: the whole shift done at once, latency from the iteration count.
  function automatic logic [63:0] ref_res(input logic [63:0] x, input int sh, input logic [1:0] o);
    case (o)
      2'b00:   return x << sh;
      2'b01:   return x >> sh;
      2'b10:   return $signed(x) >>> sh;
      default: return x;
    endcase
  endfunction

  function automatic int ref_lat(input int sh, input logic [1:0] o);
    if (sh == 0 || o == 2'b11) return 1;
    return 1 + (sh + MS - 1) / MS;
  endfunction

  task automatic issue(input logic [63:0] xa, input int xn, input logic [1:0] xop);
    int   waited = 0;
    exp_t e;
    a = xa; n = 6'(xn); op = xop; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        chk1("accept_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
        return;
      end
    end
    e.res  = ref_res(xa, xn, xop);
    e.vcyc = cyc + ref_lat(xn, xop);
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a  = {$urandom(), $urandom()};
    n  = 6'($urandom());
    op = 2'($urandom());
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // out_ready driver: 0 = hold off, 1 = always ready, 2 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: latency on first valid cycle, result every valid cycle, pop on consume.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        seen = 1'b0;
        continue;
      end
      if (exp_q.size() == 0) begin
        chk1("spurious_valid", out_valid, 1'b0);
      end else if (out_valid) begin
        if (!seen) begin
          chk("latency_cycle", 64'(cyc), 64'(exp_q[0].vcyc));
          seen = 1'b1;
        end
        chk("result", result, exp_q[0].res);
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end else if (cyc >= exp_q[0].vcyc) begin
        chk1("late_valid", out_valid, 1'b1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] held;
    int          w;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; a = '0; n = '0; op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk("rst_result", result, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk1("in_ready_after_rst", in_ready, 1'b1);
    @(posedge clk); #1;

    issue(64'hCAAAAAAAAAAAAAAA, 1, OP_SLL);  drain();
    issue(64'h000000000000000F, 4, OP_SLL);  drain();
    issue(64'h000000000000000F, 0, OP_SLL);  drain();
    issue(64'h8000000000000000, 63, OP_SRA); drain();
    issue(64'h8000000000000000, 63, OP_SRL); drain();
    issue(64'h123456789ABCDEF0, 17, OP_RSV); drain();
    issue(64'hF00000000000000F, 8, OP_SRA);  drain();

    // Backpressure: hold DONE for 5 cycles, then consume and load on the same edge.
    rdy_mode = 0;
    @(posedge clk); #2;
    issue(64'h0123456789ABCDEF, 12, OP_SRL);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk1("bp_reach_done", out_valid, 1'b1);
    held = result;
    a = 64'hFEDCBA9876543210; n = 6'd7; op = OP_SLL; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk1("bp_valid_hold", out_valid, 1'b1);
      chk("bp_result_stable", result, held);
      chk1("bp_in_ready_low", in_ready, 1'b0);
    end
    rdy_mode = 1;
    issue(64'hFEDCBA9876543210, 7, OP_SLL);
    @(negedge clk);
    chk1("b2b_busy_after_consume", busy, 1'b1);
    drain();

    // Flush mid-SHIFT, with a competing request.
    issue(64'hA5A5A5A5DEADBEEF, 40, OP_SRL);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk1("flush_in_ready", in_ready, 1'b0);
    exp_q.delete();
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk1("flush_busy", busy, 1'b0);
    chk1("flush_out_valid", out_valid, 1'b0);
    chk1("flush_in_ready_idle", in_ready, 1'b1);
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    issue(64'h8765432112345678, 33, OP_SRA); drain();

    // Reset mid-SHIFT.
    issue(64'h8000000000000000, 63, OP_SRA);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk1("rst_mid_in_ready", in_ready, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk1("rst_mid_out_valid", out_valid, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_result", result, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk1("rst_mid_in_ready_after", in_ready, 1'b1);
    @(posedge clk); #1;

    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      issue({$urandom(), $urandom()}, $urandom_range(0, 63), 2'($urandom_range(0, 3)));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
